// File: rtl/mdu_ctrl_pkg.sv
// Shared types and funct3 encodings for the MDU sequencing controller.
package mdu_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } mdu_state_e;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    function automatic logic is_div(input logic [2:0] funct3);
        return (funct3 == F3_DIV) || (funct3 == F3_DIVU) ||
               (funct3 == F3_REM) || (funct3 == F3_REMU);
    endfunction

endpackage

// File: rtl/mdu_seq_ctrl_if.sv
// Pipeline-side handshake between the E stage and the MDU sequencing controller.
interface mdu_seq_ctrl_if;

    logic        MduReqE;
    logic [2:0]  MduOpE;
    logic        DivZeroE;
    logic        KillE;
    logic        MduStart;
    logic        MduAbort;
    logic        MduSelE;
    logic        MduStallF;
    logic        MduStallD;
    logic        MduStallE;
    logic        MduFlushM;
    logic        MduBusy;
    logic [31:0] MduStallCnt;

    modport master (
        output MduReqE, MduOpE, DivZeroE, KillE,
        input  MduStart, MduAbort, MduSelE, MduStallF, MduStallD, MduStallE,
               MduFlushM, MduBusy, MduStallCnt
    );

    modport slave (
        input  MduReqE, MduOpE, DivZeroE, KillE,
        output MduStart, MduAbort, MduSelE, MduStallF, MduStallD, MduStallE,
               MduFlushM, MduBusy, MduStallCnt
    );

endinterface

// File: rtl/mdu_cycle_counter.sv
// Down-counter for the remaining RUN cycles; holds at zero instead of wrapping.
module mdu_cycle_counter #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mdu_seq_ctrl.sv
// Holds an M-extension op in Execute for its latency, then releases it into M.
module mdu_seq_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 3,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W =
        $clog2(((MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES) + 1)
) (
    input logic          clk,
    input logic          rst,
    mdu_seq_ctrl_if.slave bus
);

    // RUN covers L-1 cycles ending on count==0, so the counter is preloaded with L-2.
    localparam logic [CNT_W-1:0] MulLoad = CNT_W'(MUL_CYCLES - 2);
    localparam logic [CNT_W-1:0] DivLoad = CNT_W'(DIV_CYCLES - 2);

    mdu_state_e       state_q, state_d;
    logic             op_div, fast_path, one_cycle;
    logic [CNT_W-1:0] load_val;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic             start, abort, sel, stall;
    logic [31:0]      stall_cnt_q, stall_cnt_d;

    always_comb begin
        op_div    = is_div(bus.MduOpE);
        fast_path = op_div && bus.DivZeroE;
        one_cycle = fast_path || (op_div ? (DIV_CYCLES == 1) : (MUL_CYCLES == 1));
        load_val  = op_div ? DivLoad : MulLoad;
    end

    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        abort    = 1'b0;
        sel      = 1'b0;
        stall    = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.MduReqE && !bus.KillE) begin
                    start = 1'b1;
                    stall = 1'b1;
                    if (one_cycle) begin
                        state_d = StDone;
                    end else begin
                        cnt_load = 1'b1;
                        state_d  = StRun;
                    end
                end
            end
            StRun: begin
                if (bus.KillE) begin
                    abort   = 1'b1;
                    state_d = StIdle;
                end else begin
                    stall = 1'b1;
                    if (cnt_zero) begin
                        state_d = StDone;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            StDone: begin
                // A held MduReqE here is the same instruction leaving, never a new start.
                state_d = StIdle;
                if (bus.KillE) begin
                    abort = 1'b1;
                end else begin
                    sel = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    mdu_cycle_counter #(
        .CNT_W(CNT_W)
    ) u_cycle_counter (
        .clk       (clk),
        .rst       (rst),
        .load_i    (cnt_load),
        .load_val_i(load_val),
        .dec_i     (cnt_dec),
        .zero_o    (cnt_zero)
    );

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.MduStallE && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Combinational outputs are masked so nothing leaks out while reset is held.
    assign bus.MduStart    = start && !rst;
    assign bus.MduAbort    = abort && !rst;
    assign bus.MduSelE     = sel && !rst;
    assign bus.MduStallF   = stall && !rst;
    assign bus.MduStallD   = stall && !rst;
    assign bus.MduStallE   = stall && !rst;
    assign bus.MduFlushM   = stall && !rst;
    assign bus.MduBusy     = (state_q != StIdle) && !rst;
    assign bus.MduStallCnt = stall_cnt_q;

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Randomised self-checking bench for mdu_seq_ctrl against a cycle-schedule model.
module tb_mdu_seq_ctrl;

    localparam int unsigned MulL = 3;
    localparam int unsigned DivL = 32;

    // Output vector: start abort sel stallF stallD stallE flushM busy
    localparam logic [7:0] VStart = 8'b1000_0000;
    localparam logic [7:0] VAbort = 8'b0100_0000;
    localparam logic [7:0] VSel   = 8'b0010_0000;
    localparam logic [7:0] VStall = 8'b0001_1110;
    localparam logic [7:0] VBusy  = 8'b0000_0001;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int unsigned model_cnt = 0;

    always #5 clk = ~clk;

    mdu_seq_ctrl_if bus ();

    mdu_seq_ctrl #(
        .MUL_CYCLES(MulL),
        .DIV_CYCLES(DivL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [7:0] obs();
        return {bus.MduStart, bus.MduAbort, bus.MduSelE, bus.MduStallF, bus.MduStallD,
                bus.MduStallE, bus.MduFlushM, bus.MduBusy};
    endfunction

    function automatic int unsigned latency(input logic [2:0] op, input logic dz);
        if (op[2] && dz) return 1;
        return op[2] ? DivL : MulL;
    endfunction

    task automatic drive_quiet();
        bus.MduReqE  = 1'b0;
        bus.KillE    = 1'b0;
        bus.MduOpE   = 3'($urandom_range(7, 0));
        bus.DivZeroE = 1'($urandom_range(1, 0));
    endtask

    // One op from its first E cycle; kill_at < 0 means never killed.
    task automatic test_op(input logic [2:0] op, input logic dz, input int kill_at,
                           input bit idle_after);
        int unsigned lat = latency(op, dz);
        bit killed = 0;
        logic [7:0] exp;
        for (int k = 0; k <= int'(lat) && !killed; k++) begin
            @(negedge clk);
            bus.MduReqE  = 1'b1;
            bus.MduOpE   = op;
            bus.DivZeroE = dz;
            bus.KillE    = (k == kill_at);
            #2;
            if (k == kill_at) begin
                exp    = (k == 0) ? 8'h00 : (VAbort | VBusy);
                killed = 1;
            end else if (k < int'(lat)) begin
                exp = VStall | ((k == 0) ? VStart : VBusy);
            end else begin
                exp = VSel | VBusy;
            end
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL op%0b dz%0d cycle t%0d outputs got %b want %b",
                         op, dz, k, obs(), exp);
            end
            checks++;
            if (bus.MduStallCnt !== model_cnt) begin
                errors++;
                $display("FAIL stallcnt op%0b t%0d got %0d want %0d",
                         op, k, bus.MduStallCnt, model_cnt);
            end
            if ((exp & VStall) != 0) model_cnt++;
        end
        if (idle_after) begin
            @(negedge clk);
            drive_quiet();
            #2;
            checks++;
            if (obs() !== 8'h00) begin
                errors++;
                $display("FAIL idle after op%0b got %b want 00000000", op, obs());
            end
            checks++;
            if (bus.MduStallCnt !== model_cnt) begin
                errors++;
                $display("FAIL stallcnt idle got %0d want %0d", bus.MduStallCnt, model_cnt);
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst          = 1'b1;
            bus.MduReqE  = 1'b1;
            bus.KillE    = 1'b0;
            bus.MduOpE   = 3'($urandom_range(7, 0));
            bus.DivZeroE = 1'b0;
            #2;
            checks++;
            if (obs() !== 8'h00 || bus.MduStallCnt !== 32'd0) begin
                errors++;
                $display("FAIL reset outputs got %b cnt %0d want 0", obs(), bus.MduStallCnt);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        drive_quiet();
        #2;
        checks++;
        if (obs() !== 8'h00 || bus.MduStallCnt !== 32'd0) begin
            errors++;
            $display("FAIL reset release got %b cnt %0d want 0", obs(), bus.MduStallCnt);
        end
        model_cnt = 0;
    endtask

    task automatic test_mul();
        for (int i = 0; i < 4; i++) test_op(3'(i), 1'($urandom_range(1, 0)), -1, 1);
    endtask

    task automatic test_div();
        test_op(3'b100, 1'b0, -1, 1);
        test_op(3'($urandom_range(7, 5)), 1'b0, -1, 1);
    endtask

    task automatic test_div_zero();
        for (int i = 4; i < 8; i++) test_op(3'(i), 1'b1, -1, 1);
    endtask

    task automatic test_kill();
        test_op(3'b100, 1'b0, 10, 1);
        test_op(3'b000, 1'b0, 0, 1);
        test_op(3'b001, 1'b0, int'(MulL), 1);
        test_op(3'b110, 1'b0, int'(DivL) - 1, 1);
    endtask

    task automatic test_back_to_back();
        int unsigned base = model_cnt;
        test_op(3'b000, 1'b0, -1, 0);
        test_op(3'b011, 1'b0, -1, 1);
        checks++;
        if (bus.MduStallCnt !== base + 6) begin
            errors++;
            $display("FAIL back_to_back total got %0d want %0d", bus.MduStallCnt, base + 6);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.MduReqE  = 1'b1;
            bus.MduOpE   = 3'b100;
            bus.DivZeroE = 1'b0;
            bus.KillE    = 1'b0;
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.MduStallCnt !== model_cnt + 5) begin
            errors++;
            $display("FAIL reset_mid precount got %0d want %0d", bus.MduStallCnt, model_cnt + 5);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (obs() !== 8'h00 || bus.MduStallCnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid outputs got %b cnt %0d want 0", obs(), bus.MduStallCnt);
        end
        model_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        drive_quiet();
        for (int k = 0; k < 2; k++) begin
            #2;
            checks++;
            if (obs() !== 8'h00 || bus.MduStallCnt !== 32'd0) begin
                errors++;
                $display("FAIL reset_mid idle got %b cnt %0d want 0", obs(), bus.MduStallCnt);
            end
            @(negedge clk);
            drive_quiet();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            logic [2:0] op = 3'($urandom_range(7, 0));
            logic dz = 1'($urandom_range(1, 0));
            int kill_at = -1;
            if ($urandom_range(3, 0) == 0) kill_at = int'($urandom_range(latency(op, dz), 0));
            test_op(op, dz, kill_at, 1'($urandom_range(1, 0)));
        end
        test_op(3'b000, 1'b0, -1, 1);
    endtask

    initial begin
        rst = 1'b1;
        drive_quiet();
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_kill();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
